// File: rtl/aer_channel.sv
// aer_channel: two-channel AER output arbiter.
// Detects rising edges on four event lines and counts them in per-line
// saturating counters. It replays them one at a time as fixed-width pulses,
// with round-robin arbitration between lines.
// Optional macro AER_CHANNEL_SYNC_EN inserts a 2-flop synchronizer per input.
module aer_channel #(
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 1,
  parameter int PEND_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic Ch1Up_In,
  input  logic Ch1Down_In,
  input  logic Ch2Up_In,
  input  logic Ch2Down_In,
  output logic Ch1Up_Out,
  output logic Ch1Down_Out,
  output logic Ch2Up_Out,
  output logic Ch2Down_Out
);

  localparam int MAX_CYC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [PEND_W-1:0] CNT_MAX = {PEND_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} state_t;

  logic [3:0]             in_raw;
  logic [3:0]             in_lvl;
  logic [3:0]             lvl_q, lvl_d;
  logic [3:0]             evt;
  logic [3:0][PEND_W-1:0] cnt_q, cnt_d;
  logic [1:0]             ptr_q, ptr_d;
  logic [3:0]             out_q, out_d;
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  state_t                 state_q, state_d;
  logic                   any_pend;
  logic [1:0]             win;
  logic [1:0]             idx;
  logic [3:0]             grant;
  logic                   can_grant;

  // Line order: 0=Ch1Up, 1=Ch1Down, 2=Ch2Up, 3=Ch2Down
  assign in_raw = {Ch2Down_In, Ch2Up_In, Ch1Down_In, Ch1Up_In};

`ifdef AER_CHANNEL_SYNC_EN
  logic [3:0] sync1_q, sync1_d, sync2_q, sync2_d;

  // Synchronizer next-state: plain shift of the raw lines
  always_comb begin
    sync1_d = in_raw;
    sync2_d = sync1_q;
  end

  // Two-flop synchronizer register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign in_lvl = sync2_q;
`else
  assign in_lvl = in_raw;
`endif

  // Edge detect: the level register resets to 0, so a line high at reset release is an event
  always_comb begin
    lvl_d = in_lvl;
    evt   = in_lvl & ~lvl_q;
  end

  // Round-robin search: the lowest offset from the pointer with a pending count wins
  always_comb begin
    any_pend = 1'b0;
    win      = ptr_q;
    idx      = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (cnt_q[idx] != '0) begin
        any_pend = 1'b1;
        win      = idx;
      end
    end
  end

  // FSM next-state and output register; a grant can also happen on the last GAP cycle
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    out_d     = out_q;
    ptr_d     = ptr_q;
    grant     = 4'b0000;
    can_grant = (state_q == S_IDLE) || ((state_q == S_GAP) && (tmr_q == '0));
    case (state_q)
      S_PULSE: begin
        if (tmr_q == '0) begin
          out_d   = 4'b0000;
          state_d = S_GAP;
          tmr_d   = TMR_W'(GAP_CYCLES - 1);
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_GAP: begin
        if (tmr_q != '0) tmr_d = tmr_q - 1'b1;
        else             state_d = S_IDLE;
      end
      default: ;
    endcase
    if (can_grant && any_pend) begin
      grant   = 4'b0001 << win;
      out_d   = grant;
      state_d = S_PULSE;
      tmr_d   = TMR_W'(PULSE_CYCLES - 1);
      ptr_d   = win + 2'd1;
    end
  end

  // Pending counters: an event and a grant together cancel; an event at saturation is dropped
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (evt[i] && !grant[i] && (cnt_q[i] != CNT_MAX)) cnt_d[i] = cnt_q[i] + 1'b1;
      else if (grant[i] && !evt[i])                      cnt_d[i] = cnt_q[i] - 1'b1;
    end
  end

  // State registers, all cleared by the asynchronous reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lvl_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      out_q   <= '0;
      tmr_q   <= '0;
      state_q <= S_IDLE;
    end else begin
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      out_q   <= out_d;
      tmr_q   <= tmr_d;
      state_q <= state_d;
    end
  end

  assign Ch1Up_Out   = out_q[0];
  assign Ch1Down_Out = out_q[1];
  assign Ch2Up_Out   = out_q[2];
  assign Ch2Down_Out = out_q[3];

endmodule

// File: tb/tb_aer_channel.sv
// tb_aer_channel: scoreboard bench for aer_channel.
// A timing model predicts each output pulse (line, rise cycle) and queues it.
// A monitor pops the queue on every observed rise.
module tb_aer_channel;

  localparam int PULSE_CYCLES = 2;
  localparam int GAP_CYCLES   = 1;
  localparam int PEND_W       = 4;
  localparam int CNT_MAX      = (1 << PEND_W) - 1;

  typedef struct {
    int line;
    int t;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] in_v = 4'b0000;
  logic       Ch1Up_Out, Ch1Down_Out, Ch2Up_Out, Ch2Down_Out;
  logic [3:0] outs;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t sb_q[$];

  // model state
  logic [3:0] h0 = 4'b0, h1 = 4'b0, h2 = 4'b0, h3 = 4'b0;
  int         mcnt[4];
  int         mptr = 0;
  int         free_at = 0;
  int         cyc = 0;
  logic [3:0] prev_out = 4'b0;
  int         rise_at[4];

  aer_channel #(
    .PULSE_CYCLES(PULSE_CYCLES),
    .GAP_CYCLES  (GAP_CYCLES),
    .PEND_W      (PEND_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .Ch1Up_In   (in_v[0]),
    .Ch1Down_In (in_v[1]),
    .Ch2Up_In   (in_v[2]),
    .Ch2Down_In (in_v[3]),
    .Ch1Up_Out  (Ch1Up_Out),
    .Ch1Down_Out(Ch1Down_Out),
    .Ch2Up_Out  (Ch2Up_Out),
    .Ch2Down_Out(Ch2Down_Out)
  );

  assign outs = {Ch2Down_Out, Ch2Up_Out, Ch1Down_Out, Ch1Up_Out};

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // history of input values as sampled on each active edge
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      h0 <= 4'b0; h1 <= 4'b0; h2 <= 4'b0; h3 <= 4'b0;
    end else begin
      h0 <= in_v; h1 <= h0; h2 <= h1; h3 <= h2;
    end
  end

  // timing model + monitor, evaluated once per cycle away from the active edge
  initial begin
    logic [3:0] ev;
    int         l;
    bit         found;
    exp_t       e;
    for (int i = 0; i < 4; i++) begin mcnt[i] = 0; rise_at[i] = 0; end
    forever begin
      @(negedge clk);
      if (!reset) begin
        for (int i = 0; i < 4; i++) mcnt[i] = 0;
        mptr     = 0;
        free_at  = 0;
        prev_out = 4'b0;
      end else begin
        cyc++;
`ifdef AER_CHANNEL_SYNC_EN
        ev = h2 & ~h3;
`else
        ev = h0 & ~h1;
`endif
        found = 1'b0;
        if (cyc >= free_at) begin
          for (int k = 0; k < 4; k++) begin
            l = (mptr + k) % 4;
            if (!found && mcnt[l] > 0) begin
              found = 1'b1;
              e.line = l;
              e.t    = cyc;
              sb_q.push_back(e);
              mcnt[l]--;
              mptr    = (l + 1) % 4;
              free_at = cyc + PULSE_CYCLES + GAP_CYCLES;
            end
          end
        end
        for (int i = 0; i < 4; i++)
          if (ev[i] && mcnt[i] < CNT_MAX) mcnt[i]++;

        check("onehot0", int'($onehot0(outs)), 1);
        while (sb_q.size() > 0 && sb_q[0].t < cyc) begin
          check("missing_rise_line", -1, sb_q[0].line);
          void'(sb_q.pop_front());
        end
        for (int i = 0; i < 4; i++) begin
          if (outs[i] && !prev_out[i]) begin
            if (sb_q.size() == 0) begin
              check("unexpected_rise_line", i, -1);
            end else begin
              e = sb_q.pop_front();
              check("rise_line", i, e.line);
              check("rise_cyc", cyc, e.t);
            end
            rise_at[i] = cyc;
          end
          if (!outs[i] && prev_out[i])
            check("pulse_width", cyc - rise_at[i], PULSE_CYCLES);
        end
        prev_out = outs;
      end
    end
  end

  initial begin
    bit seen;
    // reset held with toggling inputs
    step(1);
    for (int i = 0; i < 10; i++) begin
      in_v = 4'($urandom_range(0, 15));
      step(1);
      check("rst_outs", int'(outs), 0);
    end
    in_v = 4'b0000;
    step(1);
    reset = 1'b1;
    step(10);
    check("idle_outs", int'(outs), 0);

    // single event, held high
    in_v[0] = 1'b1;
    step(40);
    in_v[0] = 1'b0;
    step(10);

    // contention from pointer 0
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    step(2);
    in_v[0] = 1'b1;
    in_v[2] = 1'b1;
    step(12);

    // Up/Down hand-over on both channels
    in_v[0] = 1'b0;
    #5 in_v[1] = 1'b1;
    @(negedge clk);
    #1 in_v[2] = 1'b0;
    #5 in_v[3] = 1'b1;
    step(10);
    in_v[1] = 1'b0;
    in_v[3] = 1'b0;
    step(10);

    // queueing on Ch2Down
    for (int i = 0; i < 3; i++) begin
      in_v[3] = 1'b1; step(1);
      in_v[3] = 1'b0; step(1);
    end
    step(15);

    // saturation: all lines hammered with 2^PEND_W+2 edges
    for (int i = 0; i < CNT_MAX + 3; i++) begin
      in_v = 4'hF; step(1);
      in_v = 4'h0; step(1);
    end
    step(250);
    check("drained_queue", sb_q.size(), 0);

    // reset asserted mid-pulse
    in_v[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (Ch1Up_Out) seen = 1'b1;
    end
    check("wait_ch1up_pulse", int'(Ch1Up_Out), 1);
    #1 reset = 1'b0;
    #1 check("rst_midpulse_outs", int'(outs), 0);
    in_v = 4'b0000;
    step(3);
    reset = 1'b1;
    step(20);

    // line already high at reset release counts as an event
    reset = 1'b0;
    in_v[0] = 1'b1;
    step(3);
    reset = 1'b1;
    step(10);
    in_v[0] = 1'b0;
    step(10);

    check("sb_leftover", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aer_channel.md
# aer_channel

Two-channel address-event (AER) output arbiter. It takes Up/Down spike-event lines from two sensor channels and detects rising edges on each line. It queues pending events per line and replays them onto four output lines as fixed-width pulses, strictly one at a time. It sits between asynchronous spiking front-ends and the downstream event encoder, which must never see two simultaneous events.

## Interface
Parameters:
- PULSE_CYCLES, 2: output pulse width in clocks (≥1).
- GAP_CYCLES, 1: minimum low clocks between consecutive output pulses (≥1).
- PEND_W, 4: width of each per-line saturating pending-event counter.

Ports:
- clk  in  1  system clock; all state is updated on the rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state.
- Ch1Up_In  in  1  channel-1 Up event line (asynchronous level).
- Ch1Down_In  in  1  channel-1 Down event line.
- Ch2Up_In  in  1  channel-2 Up event line.
- Ch2Down_In  in  1  channel-2 Down event line.
- Ch1Up_Out  out  1  registered event pulse for Ch1Up.
- Ch1Down_Out  out  1  registered event pulse for Ch1Down.
- Ch2Up_Out  out  1  registered event pulse for Ch2Up.
- Ch2Down_Out  out  1  registered event pulse for Ch2Down.

## Operation
- Line index order, fixed: 0=Ch1Up, 1=Ch1Down, 2=Ch2Up, 3=Ch2Down.
- Per line: input register chain, then edge detect. An event is a 0→1 transition of the registered level. Held-high levels produce no further events. Falling edges are ignored.
- Per line: pending counter, PEND_W bits, saturating at 2^PEND_W−1.
  - An event increments the counter; an event at saturation is dropped.
  - A grant decrements the counter.
  - Event and grant in the same cycle leave the counter unchanged.
- Arbiter: round-robin over lines with nonzero count. The search starts at the pointer; after a grant, the pointer moves to (granted+1) mod 4. The pointer resets to 0.
- FSM states and transitions:
  - IDLE: if any count > 0, grant the winning line and go to PULSE.
  - PULSE: the granted output is high for PULSE_CYCLES clocks, then go to GAP.
  - GAP: all outputs low for GAP_CYCLES clocks, then go to IDLE.
- At most one output is high in any cycle (one-hot-or-zero invariant).
- Reset values: all four outputs 0, counters 0, pointer 0, FSM IDLE, input/edge registers 0.
- An input already high when reset deasserts counts as a rising edge.
- Reset asserted mid-pulse drops the output immediately (asynchronous reset). Pending events are discarded.

## Timing
- Input sampled high at clock edge N, block idle, no contention:
  - Output rises at edge N+3 with synchronizers compiled in.
  - Output rises at edge N+1 without synchronizers.
- Output stays high for exactly PULSE_CYCLES clocks.
- Back-to-back grants: the next output rises PULSE_CYCLES+GAP_CYCLES clocks after the previous rise.
- Simultaneous events on several lines are all counted in the same cycle. They are served in round-robin order from the current pointer.
- Pulses shorter than one clock on an input may be missed; inputs must be stable for at least 2 clocks.

## Configuration
- AER_CHANNEL_SYNC_EN defined: each input passes through a 2-flop synchronizer ahead of the edge-detect register. Latency is as stated in Timing.
- AER_CHANNEL_SYNC_EN undefined: no synchronizer flops; inputs must already be synchronous to clk. Latency drops by 2 clocks.
- All other behaviour is identical with and without the macro.

## Test plan
All scenarios use defaults (PULSE_CYCLES=2, GAP_CYCLES=1) with AER_CHANNEL_SYNC_EN defined.
- Reset: hold reset=0 for 10 clocks with inputs toggling -> all outputs 0; after release with inputs low, no output activity.
- Single event: release reset, raise Ch1Up_In at edge N and hold for 40 clocks -> Ch1Up_Out high at edges N+3..N+4 only. No repeat while the input is held high.
- Contention: raise Ch1Up_In and Ch2Up_In in the same cycle -> Ch1Up_Out pulses first (pointer 0). Ch2Up_Out rises 3 clocks after the Ch1Up_Out rise. The outputs never overlap.
- Up/Down hand-over: drop Ch1Up_In, raise Ch1Down_In 5 ns later, then do the same on channel 2; Down inputs fall together after 10 clocks -> exactly one Ch1Down_Out pulse and one Ch2Down_Out pulse, round-robin ordered, no pulse on falling edges.
- Queueing: 3 rising edges on Ch2Down_In spaced 2 clocks apart -> 3 Ch2Down_Out pulses, each rise 3 clocks after the previous rise. With 2^PEND_W+2 edges, excess events beyond saturation are dropped.
- Reset mid-pulse: assert reset while Ch1Up_Out=1 -> output is 0 within the same cycle, and no pending pulse appears after release.
